// File: rtl/apu_pkg.sv
// Shared constants and types for the APU pulse-channel register writer.
package apu_pkg;

    localparam int REGS_PER_CH = 4;
    localparam int CH_BITS     = 32;
    localparam logic [1:0] ADDR_TAG = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_e;

endpackage

// File: rtl/apu_reg_channel.sv
// One channel's 4-register bank and write strobes.
// With APU_REG_SHADOW_EN defined, regs 0..2 are staged in a shadow copy and committed with reg 3.
module apu_reg_channel
    import apu_pkg::*;
(
    input  logic               apu_clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [1:0]         wr_sel,
    input  logic [7:0]         wr_data,
    output logic [CH_BITS-1:0] bank,
    output logic [3:0]         strobe
);

`ifdef APU_REG_SHADOW_EN
    logic [7:0] shadow_0;
    logic [7:0] shadow_1;
    logic [7:0] shadow_2;

    // Only a reg 3 write reaches the bank, so consumers always see a whole channel.
    always_ff @(posedge apu_clk or negedge rst_n) begin
        if (!rst_n) begin
            bank     <= '0;
            strobe   <= '0;
            shadow_0 <= '0;
            shadow_1 <= '0;
            shadow_2 <= '0;
        end else begin
            strobe <= '0;
            if (wr_en) begin
                case (wr_sel)
                    2'd0: shadow_0 <= wr_data;
                    2'd1: shadow_1 <= wr_data;
                    2'd2: shadow_2 <= wr_data;
                    default: begin
                        bank   <= {wr_data, shadow_2, shadow_1, shadow_0};
                        strobe <= 4'hF;
                    end
                endcase
            end
        end
    end
`else
    always_ff @(posedge apu_clk or negedge rst_n) begin
        if (!rst_n) begin
            bank   <= '0;
            strobe <= '0;
        end else begin
            strobe <= '0;
            if (wr_en) begin
                case (wr_sel)
                    2'd0:    bank[7:0]   <= wr_data;
                    2'd1:    bank[15:8]  <= wr_data;
                    2'd2:    bank[23:16] <= wr_data;
                    default: bank[31:24] <= wr_data;
                endcase
                strobe <= 4'b0001 << wr_sel;
            end
        end
    end
`endif

endmodule

// File: rtl/apu_reg_writer.sv
// Decodes {10,idx} + data byte packets from the host receiver into APU channel register writes.
// Optional shadow/commit behaviour per channel is enabled with APU_REG_SHADOW_EN.
module apu_reg_writer
    import apu_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                        apu_clk,
    input  logic                        rst_n,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    output logic [NUM_CH*CH_BITS-1:0]   reg_bank,
    output logic [NUM_CH*REGS_PER_CH-1:0] wr_strobe,
    output logic                        busy,
    output logic                        err
);

    localparam int NUM_REGS = NUM_CH * REGS_PER_CH;
    localparam int TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_e        state;
    state_e        state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic [5:0]    idx;
    logic [5:0]    idx_next;
    logic          err_next;
    logic          wr_en;
    logic          addr_ok;

    assign addr_ok = (rx_data[7:6] == ADDR_TAG) && ({1'b0, rx_data[5:0]} < 7'(NUM_REGS));

    always_ff @(posedge apu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
            idx   <= '0;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            idx   <= idx_next;
            err   <= err_next;
            busy  <= (state_next == DATA);
        end
    end

    // A data byte in the final timer cycle still wins over the timeout.
    always_comb begin
        state_next = state;
        timer_next = timer;
        idx_next   = idx;
        err_next   = 1'b0;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (addr_ok) begin
                        idx_next   = rx_data[5:0];
                        timer_next = '0;
                        state_next = DATA;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            DATA: begin
                if (rx_valid) begin
                    wr_en      = 1'b1;
                    state_next = IDLE;
                end else if (timer == TIMER_LAST) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        apu_reg_channel u_ch (
            .apu_clk (apu_clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en && (idx[5:2] == 4'(c))),
            .wr_sel  (idx[1:0]),
            .wr_data (rx_data),
            .bank    (reg_bank[c*CH_BITS +: CH_BITS]),
            .strobe  (wr_strobe[c*REGS_PER_CH +: REGS_PER_CH])
        );
    end

endmodule
